// File: rtl/ex_mem_stage_buf.sv
// ex_mem_stage_buf
//   EX->MEM pipeline stage with a valid/ready handshake and a two-slot skid buffer.
//   HEAD drives the MEM-facing outputs and SKID holds the second beat. Beats leave in
//   the same order they arrived. in_ready comes only from registered state and the
//   reset input, so MEM back-pressure never feeds combinationally into EX.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset, takes priority over flush
//   flush      synchronous flush; drops every in-flight beat
//   in_valid   EX presents a beat            in_ready   stage can take a beat
//   in_ctrl    packed control vector         in_alu     ALU result
//   in_rdval   Rd / store value              in_rd      destination register index
//   out_valid  HEAD holds a beat             out_ready  MEM consumes HEAD this cycle
//   out_ctrl/out_alu/out_rdval/out_rd        HEAD fields (all zero when out_valid is 0)
//   occupancy  number of beats held (0..2)
module ex_mem_stage_buf #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_rdval,
  input  logic [REG_AW-1:0] in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_rdval,
  output logic [REG_AW-1:0] out_rd,
  output logic [1:0]        occupancy
);

  localparam int BEAT_W = CTRL_W + 2 * DATA_W + REG_AW;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q;
  logic [BEAT_W-1:0] head_q;
  logic [BEAT_W-1:0] skid_q;
  logic              out_valid_q;
  logic [1:0]        occ_q;

  logic [BEAT_W-1:0] in_beat_s;
  logic              accept_s;
  logic              release_s;

  assign in_beat_s = {in_ctrl, in_alu, in_rdval, in_rd};

  // Ready is gated by reset so nothing is accepted while the stage is being cleared.
  assign in_ready  = ~reset & (state_q != ST_FULL);
  assign accept_s  = in_valid & in_ready;
  assign release_s = out_valid_q & out_ready;

  // HEAD is cleared whenever it empties, so the outputs are zero with no extra gating.
  assign {out_ctrl, out_alu, out_rdval, out_rd} = head_q;
  assign out_valid = out_valid_q;
  assign occupancy = occ_q;

  // Stage FSM: slot contents, state, and the registered valid/occupancy outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      head_q      <= {BEAT_W{1'b0}};
      skid_q      <= {BEAT_W{1'b0}};
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else if (flush) begin
      // A beat accepted this cycle is dropped too; a release here still counts as taken.
      state_q     <= ST_EMPTY;
      head_q      <= {BEAT_W{1'b0}};
      skid_q      <= {BEAT_W{1'b0}};
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            head_q      <= in_beat_s;
            state_q     <= ST_HALF;
            out_valid_q <= 1'b1;
            occ_q       <= 2'd1;
          end else begin
            state_q <= ST_EMPTY;
          end
        end
        ST_HALF: begin
          if (accept_s && !release_s) begin
            skid_q  <= in_beat_s;
            state_q <= ST_FULL;
            occ_q   <= 2'd2;
          end else if (!accept_s && release_s) begin
            head_q      <= {BEAT_W{1'b0}};
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
          end else if (accept_s && release_s) begin
            // Pass-through: the new beat replaces the departing head, occupancy unchanged.
            head_q <= in_beat_s;
          end else begin
            state_q <= ST_HALF;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a release can change anything.
          if (release_s) begin
            head_q  <= skid_q;
            skid_q  <= {BEAT_W{1'b0}};
            state_q <= ST_HALF;
            occ_q   <= 2'd1;
          end else begin
            state_q <= ST_FULL;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          head_q      <= {BEAT_W{1'b0}};
          skid_q      <= {BEAT_W{1'b0}};
          out_valid_q <= 1'b0;
          occ_q       <= 2'd0;
        end
      endcase
    end
  end

endmodule
